// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin front end for a shared shift-and-add multiplier.
// Launches one product at a time, waits a fixed latency, returns the result with its requester id.
module mul_share_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ON_CYCLES = 2,
  parameter int LATENCY   = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_on,
  input  logic [2*WIDTH-1:0] mul_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // valid must not depend on ready; ready here depends only on state and the valids.

  localparam int CNT_MAX = (ON_CYCLES > LATENCY) ? ON_CYCLES : LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_id;   // requester granted most recently; 1 gives requester 0 priority
  logic          grant0;
  logic          grant1;
  logic          hs0;
  logic          hs1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_id;
      grant1 = !last_id;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_id   <= 1'b1;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_on    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs0 || hs1) begin
            mul_a   <= hs1 ? req1_a : req0_a;
            mul_b   <= hs1 ? req1_b : req0_b;
            rsp_id  <= hs1;
            last_id <= hs1;
            mul_on  <= 1'b1;
            busy    <= 1'b1;
            cnt     <= CW'(ON_CYCLES - 1);
            state   <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            mul_on <= 1'b0;
            cnt    <= CW'(LATENCY - 1);
            state  <= WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          // The multiplier has no done flag, so the product is taken on the last counted cycle.
          if (cnt == '0) begin
            rsp_data  <= mul_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: multiplier stand-in, cycle-timeline reference model, directed tests.
module tb_mul_share_ctrl;
  localparam int WIDTH = 32;
  localparam int ON    = 2;
  localparam int LAT   = 34;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req0_valid = 1'b0;
  logic [WIDTH-1:0]   req0_a = '0;
  logic [WIDTH-1:0]   req0_b = '0;
  logic               req1_valid = 1'b0;
  logic [WIDTH-1:0]   req1_a = '0;
  logic [WIDTH-1:0]   req1_b = '0;
  logic               rsp_ready = 1'b1;
  logic               req0_ready, req1_ready, mul_on, rsp_valid, rsp_id, busy;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_out, rsp_data;
  logic [1:0]         state_dbg;

  mul_share_ctrl #(.WIDTH(WIDTH), .ON_CYCLES(ON), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_on(mul_on), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Multiplier stand-in: product is only correct from cycle LAT-1 after mul_on falls.
  logic [63:0] m_prod = '0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  always @(posedge clk) begin
    if (mul_on) begin
      m_prod <= {32'b0, mul_a} * {32'b0, mul_b};
      m_pend <= 1'b1;
      m_cnt  <= 0;
    end else if (m_pend) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign mul_out = (m_pend && m_cnt >= LAT - 1) ? m_prod : 64'hbad0_bad0_bad0_bad0;

  // ---------------- reference model + scoreboard ----------------
  logic [64:0] exp_q[$];
  bit          m_act = 0;
  int          m_t = 0;
  bit          m_id = 0;
  bit          m_last = 1;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  bit          e_r0, e_r1, e_on, e_rv, g;
  logic [64:0] pop_v;

  int acc_cyc[$];
  int acc_id[$];
  int rsp_cyc[$];
  int rsp_idl[$];
  logic [63:0] rsp_dat[$];
  int on_log[$];
  int busy_log[$];
  int on_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_a = '0; m_b = '0; m_id = 0; m_last = 1;
      exp_q.delete();
      on_cnt = 0; busy_cnt = 0;
      chk("rst_mul_on", mul_on, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_req0_ready", req0_ready, req0_valid);
      chk("rst_req1_ready", req1_ready, req1_valid && !req0_valid);
    end else begin
      g    = (req0_valid && req1_valid) ? !m_last : !req0_valid;
      e_r0 = !m_act && req0_valid && !g;
      e_r1 = !m_act && req1_valid && g;
      e_on = m_act && (cyc >= m_t + 1) && (cyc <= m_t + ON);
      e_rv = m_act && (cyc >= m_t + 1 + ON + LAT);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("mul_on", mul_on, e_on);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("busy", busy, m_act);
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      chk("rsp_id", rsp_id, m_id);
      if (e_rv) chk("rsp_data", rsp_data, {32'b0, m_a} * {32'b0, m_b});

      // observed-transaction monitor
      if (mul_on) on_cnt++;
      if (busy) busy_cnt++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(int'(req1_valid && req1_ready));
        on_cnt = 0; busy_cnt = 0;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        rsp_idl.push_back(int'(rsp_id));
        rsp_dat.push_back(rsp_data);
        on_log.push_back(on_cnt);
        busy_log.push_back(busy_cnt);
        if (exp_q.size() == 0) begin
          timeout("sb_unexpected_response");
        end else begin
          pop_v = exp_q.pop_front();
          chk("sb_response", {rsp_id, rsp_data}, pop_v);
        end
      end

      // advance the model after comparing this cycle
      if (e_r0 || e_r1) begin
        m_act = 1; m_t = cyc; m_id = g; m_last = g;
        m_a = g ? req1_a : req0_a;
        m_b = g ? req1_b : req0_b;
        exp_q.push_back({g, {32'b0, m_a} * {32'b0, m_b}});
      end else if (e_rv && rsp_ready) begin
        m_act = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b, output int waited);
    @(posedge clk); #1;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (id ? req1_ready : req0_ready) break;
      if (waited > 200) begin timeout("send_accept"); break; end
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (rsp_valid && rsp_ready) break;
      if (n > 300) begin timeout("wait_rsp"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  int w, k, base, nrsp;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // single request from requester 0
    send(0, 32'd2, 32'd23, w);
    chk("t1_ready_same_cycle", w, 1);
    wait_rsp();
    chk("t1_data", rsp_dat[$], 64'd46);
    chk("t1_id", rsp_idl[$], 0);
    chk("t1_latency", rsp_cyc[$] - acc_cyc[$], 37);
    chk("t1_on_cycles", on_log[$], 2);
    chk("t1_busy_cycles", busy_log[$], 37);
    idle(3);

    // single request from requester 1
    send(1, 32'd125, 32'd25, w);
    wait_rsp();
    chk("t2_data", rsp_dat[$], 64'd3125);
    chk("t2_id", rsp_idl[$], 1);
    chk("t2_latency", rsp_cyc[$] - acc_cyc[$], 37);
    idle(2);

    // operand stability: inputs move while busy, latched operands must not
    send(0, 32'd6, 32'd7, w);
    req0_a = 32'd1000; req0_b = 32'd3;
    idle(10);
    chk("stab_mul_a_mid", mul_a, 32'd6);
    chk("stab_mul_b_mid", mul_b, 32'd7);
    wait_rsp();
    chk("stab_data", rsp_dat[$], 64'd42);
    chk("stab_mul_a_after", mul_a, 32'd6);
    idle(2);

    // contention from reset: both valid continuously, expect 0,1,0,1
    @(posedge clk); #1 rst_n = 1'b0;
    req0_a = 32'd3; req0_b = 32'd7; req0_valid = 1'b1;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = acc_cyc.size();
    nrsp = rsp_dat.size();
    k = 0; w = 0;
    while (k < 4) begin
      @(negedge clk);
      w++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) k++;
      if (w > 400) begin timeout("contention_accepts"); break; end
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp();
    if (acc_cyc.size() >= base + 4 && rsp_dat.size() >= nrsp + 4) begin
      chk("cont_grant0", acc_id[base], 0);
      chk("cont_grant1", acc_id[base+1], 1);
      chk("cont_grant2", acc_id[base+2], 0);
      chk("cont_grant3", acc_id[base+3], 1);
      chk("cont_spacing", acc_cyc[base+1] - acc_cyc[base], 38);
      chk("cont_data0", rsp_dat[nrsp], 64'd21);
      chk("cont_data1", rsp_dat[nrsp+1], 64'hFFFF_FFFE_0000_0001);
      chk("cont_id1", rsp_idl[nrsp+1], 1);
      chk("cont_data3", rsp_dat[nrsp+3], 64'hFFFF_FFFE_0000_0001);
    end else begin
      timeout("cont_log_size");
    end
    idle(2);

    // back-pressure with a pending requester 1
    rsp_ready = 1'b0;
    send(0, 32'd9, 32'd11, w);
    req1_a = 32'd4; req1_b = 32'd4; req1_valid = 1'b1;
    w = 0;
    while (!rsp_valid) begin
      @(negedge clk);
      w++;
      if (w > 100) begin timeout("bp_rsp_valid"); break; end
    end
    repeat (10) begin
      @(negedge clk);
      chk("bp_data", rsp_data, 64'd99);
      chk("bp_id", rsp_id, 0);
      chk("bp_req1_ready", req1_ready, 0);
      chk("bp_mul_on", mul_on, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    base = acc_cyc.size();
    w = 0;
    while (1) begin
      @(negedge clk);
      w++;
      if (req1_ready) break;
      if (w > 20) begin timeout("bp_next_accept"); break; end
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    chk("bp_next_accept_gap", acc_cyc[$] - rsp_cyc[$], 1);
    wait_rsp();
    chk("bp_req1_data", rsp_dat[$], 64'd16);
    idle(2);

    // reset asserted while waiting on the multiplier
    send(0, 32'd8, 32'd8, w);
    idle(ON + 10);
    nrsp = rsp_dat.size();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_mul_on", mul_on, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(45);
    chk("mid_rst_no_rsp", rsp_dat.size(), nrsp);
    send(0, 32'd5, 32'd5, w);
    wait_rsp();
    chk("mid_rst_data", rsp_dat[$], 64'd25);
    chk("mid_rst_latency", rsp_cyc[$] - acc_cyc[$], 37);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
